// File: rtl/q_episode_seq.sv
// Episode/step sequencer that drives one shared Q-learning datapath (select, update, move) through go/done handshakes.
// Optional WAIT watchdog with ERR state enabled by defining Q_SEQ_WDOG_EN.
module q_episode_seq #(
  parameter int N_EPISODES  = 100,
  parameter int MAX_STEPS   = 64,
  parameter int STATE_W     = 6,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [STATE_W-1:0]                 start_state,
  input  logic [STATE_W-1:0]                 target_state,
  output logic                               sel_go,
  input  logic                               sel_done,
  output logic                               upd_go,
  input  logic                               upd_done,
  output logic                               mv_go,
  input  logic                               mv_done,
  input  logic [STATE_W-1:0]                 mv_next_state,
  output logic [STATE_W-1:0]                 cur_state,
  output logic [$clog2(MAX_STEPS)-1:0]       step_cnt,
  output logic [$clog2(N_EPISODES+1)-1:0]    episode_cnt,
  output logic                               busy,
  output logic                               learn_done,
  output logic                               wdog_err
);

  localparam int STEP_W = $clog2(MAX_STEPS);
  localparam int EP_W   = $clog2(N_EPISODES + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
  localparam logic [EP_W-1:0]   LAST_EP   = EP_W'(N_EPISODES - 1);

  typedef enum logic [3:0] {
    IDLE,
    SEL_ISSUE,
    SEL_WAIT,
    UPD_ISSUE,
    UPD_WAIT,
    MOV_ISSUE,
    MOV_WAIT,
    CHECK,
    DONE
`ifdef Q_SEQ_WDOG_EN
    , ERR
`endif
  } state_t;

  state_t             state_reg;
  logic [STATE_W-1:0] start_reg;
  logic [STATE_W-1:0] target_reg;
  logic [STATE_W-1:0] next_reg;
  logic               wait_done;

  // Only the done belonging to the current WAIT stage may advance the FSM.
  always_comb begin
    wait_done = 1'b0;
    case (state_reg)
      SEL_WAIT: wait_done = sel_done;
      UPD_WAIT: wait_done = upd_done;
      MOV_WAIT: wait_done = mv_done;
      default:  wait_done = 1'b0;
    endcase
  end

`ifdef Q_SEQ_WDOG_EN
  localparam int WDOG_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              in_wait;
  assign in_wait = (state_reg == SEL_WAIT) || (state_reg == UPD_WAIT) || (state_reg == MOV_WAIT);
`else
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      start_reg   <= '0;
      target_reg  <= '0;
      next_reg    <= '0;
      sel_go      <= 1'b0;
      upd_go      <= 1'b0;
      mv_go       <= 1'b0;
      cur_state   <= '0;
      step_cnt    <= '0;
      episode_cnt <= '0;
      busy        <= 1'b0;
      learn_done  <= 1'b0;
`ifdef Q_SEQ_WDOG_EN
      wdog_cnt_reg <= '0;
      wdog_err     <= 1'b0;
`endif
    end else begin
      sel_go <= 1'b0;
      upd_go <= 1'b0;
      mv_go  <= 1'b0;
      case (state_reg)
        SEL_ISSUE: state_reg <= SEL_WAIT;
        SEL_WAIT: if (wait_done) begin
          state_reg <= UPD_ISSUE;
          upd_go    <= 1'b1;
        end
        UPD_ISSUE: state_reg <= UPD_WAIT;
        UPD_WAIT: if (wait_done) begin
          state_reg <= MOV_ISSUE;
          mv_go     <= 1'b1;
        end
        MOV_ISSUE: state_reg <= MOV_WAIT;
        MOV_WAIT: if (wait_done) begin
          next_reg  <= mv_next_state;
          state_reg <= CHECK;
        end
        CHECK: begin
          if (next_reg == target_reg || step_cnt == LAST_STEP) begin
            step_cnt    <= '0;
            cur_state   <= start_reg;
            episode_cnt <= episode_cnt + 1'b1;
            if (episode_cnt == LAST_EP) begin
              state_reg  <= DONE;
              busy       <= 1'b0;
              learn_done <= 1'b1;
            end else begin
              state_reg <= SEL_ISSUE;
              sel_go    <= 1'b1;
            end
          end else begin
            step_cnt  <= step_cnt + 1'b1;
            cur_state <= next_reg;
            state_reg <= SEL_ISSUE;
            sel_go    <= 1'b1;
          end
        end
        // IDLE, DONE (and ERR) all accept a fresh start the same way.
        default: if (start) begin
          start_reg   <= start_state;
          target_reg  <= target_state;
          cur_state   <= start_state;
          step_cnt    <= '0;
          episode_cnt <= '0;
          learn_done  <= 1'b0;
          busy        <= 1'b1;
          sel_go      <= 1'b1;
          state_reg   <= SEL_ISSUE;
`ifdef Q_SEQ_WDOG_EN
          wdog_err    <= 1'b0;
`endif
        end
      endcase
`ifdef Q_SEQ_WDOG_EN
      // Counter is zero on the first WAIT cycle, so ERR follows the TIMEOUT_CYC-th silent cycle.
      if (in_wait && !wait_done) begin
        if (wdog_cnt_reg == WDOG_LAST) begin
          state_reg <= ERR;
          busy      <= 1'b0;
          wdog_err  <= 1'b1;
        end else begin
          wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        end
      end else begin
        wdog_cnt_reg <= '0;
      end
`endif
    end
  end

endmodule
